// File: rtl/ram_fill_check_sp_if.sv
// Write-stream bundle for ram_fill_check_sp: valid/ready word stream plus the
// debug error-injection strobe that travels with each word.
interface ram_fill_check_sp_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_last;
  logic                  inj_err;
  logic                  wr_ready;

  modport master (
    output wr_data, wr_valid, wr_last, inj_err,
    input  wr_ready
  );

  modport slave (
    input  wr_data, wr_valid, wr_last, inj_err,
    output wr_ready
  );
endinterface

// File: rtl/ram_fill_check_sp.sv
// Fills a single-port RAM from a word stream, then reads the filled region
// back and compares an XOR signature of the read data with that of the writes.
module ram_fill_check_sp #(
  parameter  int DATA_WIDTH = 16,
  parameter  int RAM_DEPTH  = 256,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  ram_fill_check_sp_if.slave    strm,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   fill_len
);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH:0]   addr;
  logic [DATA_WIDTH-1:0] sig_wr;
  logic [DATA_WIDTH-1:0] sig_rd;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_vld;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  assign strm.wr_ready = (state == WRITE);
  assign accept        = strm.wr_ready && strm.wr_valid;

  // RAM array is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept)
      mem[addr[ADDR_WIDTH-1:0]] <= strm.wr_data ^ DATA_WIDTH'(strm.inj_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      fill_len <= '0;
      sig_wr   <= '0;
      sig_rd   <= '0;
      rd_q     <= '0;
      rd_vld   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= WRITE;
            addr     <= '0;
            fill_len <= '0;
            sig_wr   <= '0;
            sig_rd   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
          end
        end
        WRITE: begin
          if (accept) begin
            sig_wr   <= sig_wr ^ strm.wr_data;
            fill_len <= fill_len + 1'b1;
            if (strm.wr_last || addr == LAST_ADDR) begin
              state  <= VERIFY;
              addr   <= '0;
              rd_vld <= 1'b0;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        VERIFY: begin
          // rd_q from the previous edge is folded in one cycle late; the final
          // edge folds the last word directly into the comparison.
          if (rd_vld)
            sig_rd <= sig_rd ^ rd_q;
          if (addr == fill_len) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ((sig_rd ^ rd_q) == sig_wr);
          end else begin
            rd_q   <= mem[addr[ADDR_WIDTH-1:0]];
            rd_vld <= 1'b1;
            addr   <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fill_check_sp.sv
// Directed and randomized fills of ram_fill_check_sp checked against a
// signature model computed from the words offered to the stream.
module tb_ram_fill_check_sp;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, pass;
  logic [8:0] fill_len;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] w_data [256];
  bit          w_inj  [256];
  int          w_gap  [256];

  ram_fill_check_sp_if #(.DATA_WIDTH(16)) bus ();

  ram_fill_check_sp #(.DATA_WIDTH(16), .RAM_DEPTH(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .strm     (bus.slave),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fill_len (fill_len)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_words();
    for (int i = 0; i < 256; i++) begin
      w_data[i] = '0;
      w_inj[i]  = 1'b0;
      w_gap[i]  = 0;
    end
  endtask

  // Drives one complete fill from IDLE/DONE and checks the outcome against
  // the XOR of the offered words versus the XOR of what lands in RAM.
  task automatic run_fill(input string tag, input int n, input bit use_last,
                          input bit st_wr, input bit st_vf);
    int          rdy_cyc;
    int          vcyc;
    logic [15:0] sw;
    logic [15:0] sr;
    rdy_cyc = 0;
    vcyc    = 0;
    sw      = '0;
    sr      = '0;
    for (int i = 0; i < n; i++) begin
      sw = sw ^ w_data[i];
      sr = sr ^ (w_data[i] ^ {15'b0, w_inj[i]});
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":busy_at_start"}, 32'(busy), 32'd1);
    chk({tag, ":done_cleared"},  32'(done), 32'd0);
    chk({tag, ":len_cleared"},   32'(fill_len), 32'd0);

    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < w_gap[i]; g++) begin
        bus.wr_valid = 1'b0;
        @(negedge clk);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = w_data[i];
      bus.wr_last  = use_last && (i == n - 1);
      bus.inj_err  = w_inj[i];
      start        = st_wr && (i == n / 2);
      if (bus.wr_ready) rdy_cyc++;
      @(negedge clk);
      start = 1'b0;
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.inj_err  = 1'b0;

    chk({tag, ":ready_low_after_fill"}, 32'(bus.wr_ready), 32'd0);
    chk({tag, ":ready_cycles"},         32'(rdy_cyc), 32'(n));

    while (busy && vcyc < 2000) begin
      start = st_vf && (vcyc == 1);
      @(negedge clk);
      start = 1'b0;
      vcyc++;
    end
    chk({tag, ":verify_cycles"}, 32'(vcyc), 32'(n + 1));
    chk({tag, ":done"},          32'(done), 32'd1);
    chk({tag, ":pass"},          32'(pass), 32'(sw == sr));
    chk({tag, ":fill_len"},      32'(fill_len), 32'(n));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.inj_err  = 1'b0;
    #1;
    chk("reset:busy",     32'(busy), 32'd0);
    chk("reset:done",     32'(done), 32'd0);
    chk("reset:pass",     32'(pass), 32'd0);
    chk("reset:ready",    32'(bus.wr_ready), 32'd0);
    chk("reset:fill_len", 32'(fill_len), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle:ready", 32'(bus.wr_ready), 32'd0);

    // Four one-hot-nibble words with wr_last on the fourth.
    clear_words();
    w_data[0] = 16'h1111; w_data[1] = 16'h2222;
    w_data[2] = 16'h4444; w_data[3] = 16'h8888;
    run_fill("four_words", 4, 1'b1, 1'b0, 1'b0);

    // Full-depth fill exits on the last address without wr_last.
    clear_words();
    for (int i = 0; i < 256; i++) w_data[i] = 16'(i);
    run_fill("full_depth", 256, 1'b0, 1'b0, 1'b0);

    // Corrupt word 2 in RAM only, then a clean re-run.
    clear_words();
    w_data[0] = 16'h1111; w_data[1] = 16'h2222;
    w_data[2] = 16'h4444; w_data[3] = 16'h8888;
    w_inj[1] = 1'b1;
    run_fill("inj_err", 4, 1'b1, 1'b0, 1'b0);
    w_inj[1] = 1'b0;
    run_fill("rerun_clean", 4, 1'b1, 1'b0, 1'b0);

    // Valid pattern 1,0,0,1,0,1.
    clear_words();
    w_data[0] = 16'hA5A5; w_data[1] = 16'h5A5A; w_data[2] = 16'hFFFF;
    w_gap[1] = 2; w_gap[2] = 1;
    run_fill("gapped", 3, 1'b1, 1'b0, 1'b0);

    // Reset two words into a fill.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h0F00 + 16'(i);
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset:busy",     32'(busy), 32'd0);
    chk("midreset:done",     32'(done), 32'd0);
    chk("midreset:pass",     32'(pass), 32'd0);
    chk("midreset:ready",    32'(bus.wr_ready), 32'd0);
    chk("midreset:fill_len", 32'(fill_len), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_words();
    w_data[0] = 16'hBEEF;
    run_fill("after_reset_one", 1, 1'b1, 1'b0, 1'b0);

    // start pulses during WRITE and VERIFY must be ignored.
    clear_words();
    for (int i = 0; i < 6; i++) w_data[i] = 16'h1357 * 16'(i + 1);
    run_fill("start_ignored", 6, 1'b1, 1'b1, 1'b1);

    // Randomized fills, occasionally full depth and with RAM-only corruption.
    for (int r = 0; r < 10; r++) begin
      int  n;
      bit  lst;
      clear_words();
      n   = ($urandom_range(0, 4) == 0) ? 256 : int'($urandom_range(1, 48));
      lst = (n < 256) ? 1'b1 : 1'(($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
        w_data[i] = 16'($urandom);
        w_inj[i]  = ($urandom_range(0, 15) == 0);
        w_gap[i]  = int'($urandom_range(0, 2));
      end
      run_fill($sformatf("rand%0d", r), n, lst, 1'(($urandom_range(0, 1))),
               1'(($urandom_range(0, 1))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
